dpcd_lt_responder: RTL and testbench
====================================

Name: dpcd_lt_responder

Overview:
- Sink-side DPCD register responder for DisplayPort link training: the far end of the source's clock-recovery/channel-EQ AUX transactions.
- Accepts decoded native AUX read/write requests from the sink AUX PHY. Returns ACK/NACK and read data.
- Holds the link-configuration and training DPCD registers and drives them to the receiver PHY.
- Reports per-lane lock status and adjust requests back to the source.

Parameters:
- DPCD_REV, 8'h12, value at 0x00000.
- MAX_LINK_RATE, 8'h1E, value at 0x00001; also the upper bound for LINK_BW_SET writes.
- MAX_LANE_COUNT, 3'd4, 0x00002 bits[4:0].
- TPS3_SUPPORTED, 1'b1, 0x00002 bit6.
- RD_INTERVAL, 8'h00, value at 0x0000E.

Ports:
- clk  in  1  link-layer clock
- rst  in  1  synchronous, active-high reset
- aux_transaction_vld  in  1  one-cycle request strobe
- aux_cmd  in  2  2'b00 native write, 2'b01 native read, others reserved
- aux_address  in  20  start address
- aux_len  in  8  byte count minus 1
- aux_wr_data  in  8  write byte
- aux_wr_data_vld  in  1  write byte strobe
- aux_rd_data  out  8  read byte
- aux_rd_data_vld  out  1  read byte strobe
- aux_ack  out  1  one-cycle ACK pulse
- aux_nack  out  1  one-cycle NACK pulse
- phy_cr_lock  in  4  per-lane CR done
- phy_eq_done  in  4  per-lane channel EQ done
- phy_symbol_lock  in  4  per-lane symbol lock
- phy_interlane_align  in  1  inter-lane alignment done
- phy_adj_vtg  in  8  requested swing, 2 bits per lane, lane0 in [1:0]
- phy_adj_pre  in  8  requested pre-emphasis, 2 bits per lane
- rx_link_bw  out  8  LINK_BW_SET
- rx_lane_count  out  2  00=1, 01=2, 10=4 lanes
- rx_tps  out  2  TRAINING_PATTERN_SET[1:0]
- rx_vtg  out  8  TRAINING_LANEx_SET swing, 2 bits per lane
- rx_pre  out  8  TRAINING_LANEx_SET pre-emphasis, 2 bits per lane

Behaviour:
- Reset (synchronous, active-high):
  - rx_link_bw=8'h06, rx_lane_count=2'b00, rx_tps=0, rx_vtg=0, rx_pre=0.
  - aux_ack, aux_nack, aux_rd_data_vld = 0; aux_rd_data=0.
  - FSM goes to IDLE. Reset aborts any transaction in flight; no response is issued for it.
- FSM states: IDLE, WR_DATA, RD_DATA, RESP_ACK, RESP_NACK.
- IDLE:
  - aux_transaction_vld with reserved cmd or aux_len>15 -> RESP_NACK.
  - Write -> WR_DATA. Read -> RD_DATA.
  - Address and the remaining-byte counter are latched on the strobe.
- WR_DATA:
  - Each aux_wr_data_vld writes one byte to the current address, then the address increments.
  - After byte aux_len+1 -> RESP_ACK.
  - Gaps between data strobes are allowed.
- RD_DATA:
  - aux_rd_data_vld is high for aux_len+1 consecutive cycles, starting the cycle after the strobe.
  - Address increments each cycle; then -> RESP_ACK.
- RESP_ACK / RESP_NACK: pulse aux_ack / aux_nack for 1 cycle, then return to IDLE.
- aux_transaction_vld outside IDLE is ignored: no response, no state change.
- Address arithmetic is 20-bit and wraps 0xFFFFF->0x00000.
- Unmapped addresses read 8'h00 and ignore writes; the transaction is still ACKed.
- Register map:
  - 0x00000-0x00002: read-only capabilities from parameters.
  - 0x0000E: RD_INTERVAL, read-only.
  - 0x00100 LINK_BW_SET: write accepted only if the value is in {06,0A,14,1E} and <=MAX_LINK_RATE; otherwise the register holds.
  - 0x00101 LANE_COUNT_SET: bits[4:0] must be 1, 2 or 4 and <=MAX_LANE_COUNT; otherwise the register holds. Reads return the encoded count (1/2/4).
  - 0x00102 TRAINING_PATTERN_SET: bits[1:0] drive rx_tps. A value of 3 when TPS3_SUPPORTED=0 is ignored.
  - 0x00103-0x00106 TRAINING_LANE0..3_SET: bits[1:0] = swing, bits[4:3] = pre-emphasis.
  - 0x00202 LANE0_1_STATUS and 0x00203 LANE2_3_STATUS: per-lane nibble, bit0 CR_DONE, bit1 CHANNEL_EQ_DONE, bit2 SYMBOL_LOCKED.
  - 0x00204: bit0 INTERLANE_ALIGN_DONE.
  - 0x00206/0x00207 ADJUST_REQUEST: per-lane nibble, swing [1:0], pre [3:2], from phy_adj_*.
- Status inputs are registered one cycle before they are visible to reads.
- Lanes >= active lane count read 0 in status and adjust bytes.
- A read or write crossing register boundaries handles each byte at its own address.

Optional Feature:
- Macro: LT_IRQ_EN.
- Defined:
  - Adds output port hpd_irq (1 bit).
  - While rx_tps==0 (training finished), a 1->0 transition of any active-lane CR_DONE, SYMBOL_LOCKED or interlane-align bit fires a one-cycle hpd_irq pulse.
  - hpd_irq=0 in reset.
- Undefined: the port and its logic are absent; all other behaviour is unchanged.

Test Plan:
- Reset -> rx_link_bw=06, rx_lane_count=00, rx_tps=0, rx_vtg=0, rx_pre=0; no ack/nack/rd_data_vld.
- Write 0x00100, len=2, bytes 0A,02,01 -> rx_link_bw=0A, rx_lane_count=01, rx_tps=01; aux_ack pulse the cycle after the 3rd byte's FSM update.
- Read 0x00000, len=2 -> rd bytes 12,1E,44 on 3 consecutive cycles, then aux_ack.
- Lane count 2, phy_cr_lock=F, phy_eq_done=0, phy_symbol_lock=0; read 0x00202 len=2 -> 11,00,00.
- Write 0x00101 data 03 -> lane count unchanged, ACK. Request with aux_len=16 -> aux_nack only. Reserved cmd -> aux_nack only. Strobe during RD_DATA -> ignored.
- LT_IRQ_EN defined: rx_tps=0, 1 lane, phy_cr_lock 1->0 -> one hpd_irq pulse. Same drop with rx_tps=1 -> no pulse.

Source files
------------

// File: rtl/dpcd_lt_responder_if.sv
// rtl/dpcd_lt_responder_if.sv - native AUX request/response bundle between sink AUX PHY and DPCD responder
interface dpcd_lt_responder_if;
    logic        aux_transaction_vld;
    logic [1:0]  aux_cmd;
    logic [19:0] aux_address;
    logic [7:0]  aux_len;
    logic [7:0]  aux_wr_data;
    logic        aux_wr_data_vld;
    logic [7:0]  aux_rd_data;
    logic        aux_rd_data_vld;
    logic        aux_ack;
    logic        aux_nack;

    modport master (
        output aux_transaction_vld, aux_cmd, aux_address, aux_len, aux_wr_data, aux_wr_data_vld,
        input  aux_rd_data, aux_rd_data_vld, aux_ack, aux_nack
    );

    modport slave (
        input  aux_transaction_vld, aux_cmd, aux_address, aux_len, aux_wr_data, aux_wr_data_vld,
        output aux_rd_data, aux_rd_data_vld, aux_ack, aux_nack
    );
endinterface

// File: rtl/dpcd_lt_responder.sv
// rtl/dpcd_lt_responder.sv - sink DPCD link-training register responder (optional LT_IRQ_EN adds hpd_irq)
module dpcd_lt_responder #(
    parameter logic [7:0] DPCD_REV       = 8'h12,
    parameter logic [7:0] MAX_LINK_RATE  = 8'h1E,
    parameter logic [2:0] MAX_LANE_COUNT = 3'd4,
    parameter logic       TPS3_SUPPORTED = 1'b1,
    parameter logic [7:0] RD_INTERVAL    = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst,
    dpcd_lt_responder_if.slave   aux,
    input  logic [3:0]           phy_cr_lock,
    input  logic [3:0]           phy_eq_done,
    input  logic [3:0]           phy_symbol_lock,
    input  logic                 phy_interlane_align,
    input  logic [7:0]           phy_adj_vtg,
    input  logic [7:0]           phy_adj_pre,
    output logic [7:0]           rx_link_bw,
    output logic [1:0]           rx_lane_count,
    output logic [1:0]           rx_tps,
    output logic [7:0]           rx_vtg,
    output logic [7:0]           rx_pre
`ifdef LT_IRQ_EN
    ,
    output logic                 hpd_irq
`endif
);

    typedef enum logic [2:0] {IDLE, WR_DATA, RD_DATA, RESP_ACK, RESP_NACK} state_t;

    state_t      state_q, state_d;
    logic [19:0] addr_q, addr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  link_bw_q, link_bw_d;
    logic [1:0]  lane_cnt_q, lane_cnt_d;
    logic [1:0]  tps_q, tps_d;
    logic [7:0]  vtg_q, vtg_d;
    logic [7:0]  pre_q, pre_d;
    logic        ack_q, ack_d;
    logic        nack_q, nack_d;
    logic        rd_vld_q, rd_vld_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic [3:0]  cr_q, cr_d, eq_q, eq_d, sym_q, sym_d;
    logic        align_q, align_d;
    logic [7:0]  adj_vtg_q, adj_vtg_d, adj_pre_q, adj_pre_d;
    logic        irq_q, irq_d;

    logic [3:0]  lane_mask;
    logic [7:0]  mask2;
    logic [3:0]  cr_m, eq_m, sym_m;
    logic [7:0]  adj_vtg_m, adj_pre_m;
    logic [19:0] rd_addr;
    logic [7:0]  rd_byte;
    logic [7:0]  wd;

    // Active-lane mask and masked status/adjust views used by register reads
    always_comb begin
        case (lane_cnt_q)
            2'b00:   lane_mask = 4'b0001;
            2'b01:   lane_mask = 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
        mask2     = {{2{lane_mask[3]}}, {2{lane_mask[2]}}, {2{lane_mask[1]}}, {2{lane_mask[0]}}};
        cr_m      = cr_q & lane_mask;
        eq_m      = eq_q & lane_mask;
        sym_m     = sym_q & lane_mask;
        adj_vtg_m = adj_vtg_q & mask2;
        adj_pre_m = adj_pre_q & mask2;
    end

    // Read mux: the first byte comes straight from the request address, later bytes from the running address
    always_comb begin
        rd_addr = (state_q == IDLE) ? aux.aux_address : addr_q;
        case (rd_addr)
            20'h00000: rd_byte = DPCD_REV;
            20'h00001: rd_byte = MAX_LINK_RATE;
            20'h00002: rd_byte = {1'b0, TPS3_SUPPORTED, 3'b000, MAX_LANE_COUNT};
            20'h0000E: rd_byte = RD_INTERVAL;
            20'h00100: rd_byte = link_bw_q;
            20'h00101: rd_byte = (lane_cnt_q == 2'b00) ? 8'h01 : (lane_cnt_q == 2'b01) ? 8'h02 : 8'h04;
            20'h00102: rd_byte = {6'b0, tps_q};
            20'h00103: rd_byte = {3'b0, pre_q[1:0], 1'b0, vtg_q[1:0]};
            20'h00104: rd_byte = {3'b0, pre_q[3:2], 1'b0, vtg_q[3:2]};
            20'h00105: rd_byte = {3'b0, pre_q[5:4], 1'b0, vtg_q[5:4]};
            20'h00106: rd_byte = {3'b0, pre_q[7:6], 1'b0, vtg_q[7:6]};
            20'h00202: rd_byte = {1'b0, sym_m[1], eq_m[1], cr_m[1], 1'b0, sym_m[0], eq_m[0], cr_m[0]};
            20'h00203: rd_byte = {1'b0, sym_m[3], eq_m[3], cr_m[3], 1'b0, sym_m[2], eq_m[2], cr_m[2]};
            20'h00204: rd_byte = {7'b0, align_q};
            20'h00206: rd_byte = {adj_pre_m[3:2], adj_vtg_m[3:2], adj_pre_m[1:0], adj_vtg_m[1:0]};
            20'h00207: rd_byte = {adj_pre_m[7:6], adj_vtg_m[7:6], adj_pre_m[5:4], adj_vtg_m[5:4]};
            default:   rd_byte = 8'h00;
        endcase
    end

    // Next-state logic: request decode, byte sequencing and validated register writes
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        link_bw_d  = link_bw_q;
        lane_cnt_d = lane_cnt_q;
        tps_d      = tps_q;
        vtg_d      = vtg_q;
        pre_d      = pre_q;
        ack_d      = 1'b0;
        nack_d     = 1'b0;
        rd_vld_d   = 1'b0;
        rd_data_d  = rd_data_q;
        wd         = aux.aux_wr_data;
        cr_d       = phy_cr_lock;
        eq_d       = phy_eq_done;
        sym_d      = phy_symbol_lock;
        align_d    = phy_interlane_align;
        adj_vtg_d  = phy_adj_vtg;
        adj_pre_d  = phy_adj_pre;

        case (state_q)
            IDLE: begin
                if (aux.aux_transaction_vld) begin
                    if (aux.aux_cmd[1] || (aux.aux_len > 8'd15)) begin
                        state_d = RESP_NACK;
                    end else if (aux.aux_cmd == 2'b00) begin
                        addr_d  = aux.aux_address;
                        cnt_d   = aux.aux_len;
                        state_d = WR_DATA;
                    end else begin
                        addr_d    = aux.aux_address + 20'd1;
                        cnt_d     = aux.aux_len;
                        rd_vld_d  = 1'b1;
                        rd_data_d = rd_byte;
                        state_d   = (aux.aux_len == 8'd0) ? RESP_ACK : RD_DATA;
                    end
                end
            end
            WR_DATA: begin
                if (aux.aux_wr_data_vld) begin
                    case (addr_q)
                        20'h00100: begin
                            if ((wd == 8'h06 || wd == 8'h0A || wd == 8'h14 || wd == 8'h1E) && (wd <= MAX_LINK_RATE))
                                link_bw_d = wd;
                        end
                        20'h00101: begin
                            if (wd[4:0] <= {2'b00, MAX_LANE_COUNT}) begin
                                case (wd[4:0])
                                    5'd1:    lane_cnt_d = 2'b00;
                                    5'd2:    lane_cnt_d = 2'b01;
                                    5'd4:    lane_cnt_d = 2'b10;
                                    default: lane_cnt_d = lane_cnt_q;
                                endcase
                            end
                        end
                        20'h00102: begin
                            if (!(wd[1:0] == 2'b11 && !TPS3_SUPPORTED))
                                tps_d = wd[1:0];
                        end
                        20'h00103: begin vtg_d[1:0] = wd[1:0]; pre_d[1:0] = wd[4:3]; end
                        20'h00104: begin vtg_d[3:2] = wd[1:0]; pre_d[3:2] = wd[4:3]; end
                        20'h00105: begin vtg_d[5:4] = wd[1:0]; pre_d[5:4] = wd[4:3]; end
                        20'h00106: begin vtg_d[7:6] = wd[1:0]; pre_d[7:6] = wd[4:3]; end
                        default: ;
                    endcase
                    addr_d = addr_q + 20'd1;
                    cnt_d  = cnt_q - 8'd1;
                    if (cnt_q == 8'd0)
                        state_d = RESP_ACK;
                end
            end
            RD_DATA: begin
                rd_vld_d  = 1'b1;
                rd_data_d = rd_byte;
                addr_d    = addr_q + 20'd1;
                cnt_d     = cnt_q - 8'd1;
                if (cnt_q == 8'd1)
                    state_d = RESP_ACK;
            end
            RESP_ACK: begin
                ack_d   = 1'b1;
                state_d = IDLE;
            end
            RESP_NACK: begin
                nack_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Link-status loss detector: any active-lane lock falling while no training pattern is set
    always_comb begin
        irq_d = (tps_q == 2'b00) &&
                ((|(((cr_q & ~phy_cr_lock) | (sym_q & ~phy_symbol_lock)) & lane_mask)) ||
                 (align_q & ~phy_interlane_align));
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= 20'd0;
            cnt_q      <= 8'd0;
            link_bw_q  <= 8'h06;
            lane_cnt_q <= 2'b00;
            tps_q      <= 2'b00;
            vtg_q      <= 8'd0;
            pre_q      <= 8'd0;
            ack_q      <= 1'b0;
            nack_q     <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_data_q  <= 8'd0;
            cr_q       <= 4'd0;
            eq_q       <= 4'd0;
            sym_q      <= 4'd0;
            align_q    <= 1'b0;
            adj_vtg_q  <= 8'd0;
            adj_pre_q  <= 8'd0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            link_bw_q  <= link_bw_d;
            lane_cnt_q <= lane_cnt_d;
            tps_q      <= tps_d;
            vtg_q      <= vtg_d;
            pre_q      <= pre_d;
            ack_q      <= ack_d;
            nack_q     <= nack_d;
            rd_vld_q   <= rd_vld_d;
            rd_data_q  <= rd_data_d;
            cr_q       <= cr_d;
            eq_q       <= eq_d;
            sym_q      <= sym_d;
            align_q    <= align_d;
            adj_vtg_q  <= adj_vtg_d;
            adj_pre_q  <= adj_pre_d;
            irq_q      <= irq_d;
        end
    end

    assign aux.aux_ack         = ack_q;
    assign aux.aux_nack        = nack_q;
    assign aux.aux_rd_data_vld = rd_vld_q;
    assign aux.aux_rd_data     = rd_data_q;
    assign rx_link_bw          = link_bw_q;
    assign rx_lane_count       = lane_cnt_q;
    assign rx_tps              = tps_q;
    assign rx_vtg              = vtg_q;
    assign rx_pre              = pre_q;
`ifdef LT_IRQ_EN
    assign hpd_irq             = irq_q;
`endif

endmodule

// File: tb/tb_dpcd_lt_responder.sv
// tb/tb_dpcd_lt_responder.sv - directed self-checking bench for dpcd_lt_responder
module tb_dpcd_lt_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] phy_cr_lock, phy_eq_done, phy_symbol_lock;
    logic       phy_interlane_align;
    logic [7:0] phy_adj_vtg, phy_adj_pre;
    logic [7:0] rx_link_bw, rx_vtg, rx_pre;
    logic [1:0] rx_lane_count, rx_tps;
`ifdef LT_IRQ_EN
    logic       hpd_irq;
    int         irq_cnt;
`endif

    int checks = 0;
    int errors = 0;

    dpcd_lt_responder_if aux_if ();

    dpcd_lt_responder dut (
        .clk                 (clk),
        .rst                 (rst),
        .aux                 (aux_if),
        .phy_cr_lock         (phy_cr_lock),
        .phy_eq_done         (phy_eq_done),
        .phy_symbol_lock     (phy_symbol_lock),
        .phy_interlane_align (phy_interlane_align),
        .phy_adj_vtg         (phy_adj_vtg),
        .phy_adj_pre         (phy_adj_pre),
        .rx_link_bw          (rx_link_bw),
        .rx_lane_count       (rx_lane_count),
        .rx_tps              (rx_tps),
        .rx_vtg              (rx_vtg),
        .rx_pre              (rx_pre)
`ifdef LT_IRQ_EN
        ,
        .hpd_irq             (hpd_irq)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic aux_write(input logic [19:0] a, input logic [7:0] len, input logic [31:0] data, input string tag);
        @(negedge clk);
        aux_if.aux_transaction_vld = 1'b1;
        aux_if.aux_cmd             = 2'b00;
        aux_if.aux_address         = a;
        aux_if.aux_len             = len;
        @(negedge clk);
        aux_if.aux_transaction_vld = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            aux_if.aux_wr_data     = data[8*i +: 8];
            aux_if.aux_wr_data_vld = 1'b1;
            @(negedge clk);
            aux_if.aux_wr_data_vld = 1'b0;
            if (i < int'(len)) @(negedge clk);
        end
        check_eq({tag, " pre_ack"}, {30'b0, aux_if.aux_ack, aux_if.aux_nack}, 32'h0);
        @(negedge clk);
        check_eq({tag, " ack"}, {30'b0, aux_if.aux_ack, aux_if.aux_nack}, 32'h2);
        @(negedge clk);
        check_eq({tag, " ack_end"}, {30'b0, aux_if.aux_ack, aux_if.aux_nack}, 32'h0);
    endtask

    task automatic aux_read(input logic [19:0] a, input logic [7:0] len, input logic [31:0] exp, input string tag);
        @(negedge clk);
        aux_if.aux_transaction_vld = 1'b1;
        aux_if.aux_cmd             = 2'b01;
        aux_if.aux_address         = a;
        aux_if.aux_len             = len;
        @(negedge clk);
        aux_if.aux_transaction_vld = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            check_eq($sformatf("%s byte%0d", tag, i), {23'b0, aux_if.aux_rd_data_vld, aux_if.aux_rd_data},
                     {23'b0, 1'b1, exp[8*i +: 8]});
            @(negedge clk);
        end
        check_eq({tag, " ack"}, {30'b0, aux_if.aux_ack, aux_if.aux_rd_data_vld}, 32'h2);
        @(negedge clk);
        check_eq({tag, " ack_end"}, {31'b0, aux_if.aux_ack}, 32'h0);
    endtask

    task automatic aux_bad(input logic [1:0] cmd, input logic [7:0] len, input string tag);
        @(negedge clk);
        aux_if.aux_transaction_vld = 1'b1;
        aux_if.aux_cmd             = cmd;
        aux_if.aux_address         = 20'h00100;
        aux_if.aux_len             = len;
        @(negedge clk);
        aux_if.aux_transaction_vld = 1'b0;
        check_eq({tag, " pre"}, {29'b0, aux_if.aux_ack, aux_if.aux_nack, aux_if.aux_rd_data_vld}, 32'h0);
        @(negedge clk);
        check_eq({tag, " nack"}, {29'b0, aux_if.aux_ack, aux_if.aux_nack, aux_if.aux_rd_data_vld}, 32'h2);
        @(negedge clk);
        check_eq({tag, " end"}, {29'b0, aux_if.aux_ack, aux_if.aux_nack, aux_if.aux_rd_data_vld}, 32'h0);
    endtask

    initial begin
        rst                        = 1'b1;
        aux_if.aux_transaction_vld = 1'b0;
        aux_if.aux_cmd             = 2'b00;
        aux_if.aux_address         = 20'd0;
        aux_if.aux_len             = 8'd0;
        aux_if.aux_wr_data         = 8'd0;
        aux_if.aux_wr_data_vld     = 1'b0;
        phy_cr_lock                = 4'h0;
        phy_eq_done                = 4'h0;
        phy_symbol_lock            = 4'h0;
        phy_interlane_align        = 1'b0;
        phy_adj_vtg                = 8'h00;
        phy_adj_pre                = 8'h00;

        repeat (3) @(negedge clk);
        check_eq("rst link_bw", {24'b0, rx_link_bw}, 32'h06);
        check_eq("rst lane_tps", {28'b0, rx_lane_count, rx_tps}, 32'h0);
        check_eq("rst vtg_pre", {16'b0, rx_vtg, rx_pre}, 32'h0);
        check_eq("rst resp", {21'b0, aux_if.aux_ack, aux_if.aux_nack, aux_if.aux_rd_data_vld, aux_if.aux_rd_data}, 32'h0);
        rst = 1'b0;

        // Reset in the middle of a write: no response, registers back to defaults
        @(negedge clk);
        aux_if.aux_transaction_vld = 1'b1;
        aux_if.aux_cmd             = 2'b00;
        aux_if.aux_address         = 20'h00100;
        aux_if.aux_len             = 8'd1;
        @(negedge clk);
        aux_if.aux_transaction_vld = 1'b0;
        aux_if.aux_wr_data         = 8'h14;
        aux_if.aux_wr_data_vld     = 1'b1;
        @(negedge clk);
        aux_if.aux_wr_data_vld     = 1'b0;
        rst                        = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("abort resp%0d", i), {30'b0, aux_if.aux_ack, aux_if.aux_nack}, 32'h0);
            @(negedge clk);
        end
        check_eq("abort link_bw", {24'b0, rx_link_bw}, 32'h06);

        aux_write(20'h00100, 8'd2, 32'h0001020A, "wr_cfg");
        check_eq("cfg link_bw", {24'b0, rx_link_bw}, 32'h0A);
        check_eq("cfg lane", {30'b0, rx_lane_count}, 32'h1);
        check_eq("cfg tps", {30'b0, rx_tps}, 32'h1);

        aux_read(20'h00000, 8'd2, 32'h00441E12, "rd_caps");

        phy_cr_lock = 4'hF;
        repeat (2) @(negedge clk);
        aux_read(20'h00202, 8'd2, 32'h00000011, "rd_stat2");

        aux_write(20'h00101, 8'd0, 32'h03, "wr_lane3");
        check_eq("lane3 held", {30'b0, rx_lane_count}, 32'h1);

        aux_bad(2'b01, 8'd16, "len16");
        aux_bad(2'b11, 8'd0, "rsvd_cmd");

        // Strobe held high through a read: ignored until the read completes
        @(negedge clk);
        aux_if.aux_transaction_vld = 1'b1;
        aux_if.aux_cmd             = 2'b01;
        aux_if.aux_address         = 20'h00000;
        aux_if.aux_len             = 8'd3;
        @(negedge clk);
        aux_if.aux_cmd = 2'b10;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("busy byte%0d", i), {22'b0, aux_if.aux_nack, aux_if.aux_rd_data_vld, aux_if.aux_rd_data},
                     {22'b0, 1'b0, 1'b1, (i == 0) ? 8'h12 : (i == 1) ? 8'h1E : (i == 2) ? 8'h44 : 8'h00});
            @(negedge clk);
        end
        check_eq("busy ack", {30'b0, aux_if.aux_ack, aux_if.aux_nack}, 32'h2);
        aux_if.aux_transaction_vld = 1'b0;
        @(negedge clk);
        check_eq("busy end", {30'b0, aux_if.aux_ack, aux_if.aux_nack}, 32'h0);

        aux_write(20'h00100, 8'd0, 32'h08, "wr_bw08");
        check_eq("bw08 held", {24'b0, rx_link_bw}, 32'h0A);
        aux_write(20'h00100, 8'd0, 32'h1E, "wr_bw1e");
        check_eq("bw1e", {24'b0, rx_link_bw}, 32'h1E);

        aux_write(20'h00103, 8'd3, 32'h0812091B, "wr_lanes");
        check_eq("lanes vtg", {24'b0, rx_vtg}, 32'h27);
        check_eq("lanes pre", {24'b0, rx_pre}, 32'h67);
        aux_read(20'h00103, 8'd3, 32'h0812091B, "rd_lanes");

        phy_adj_vtg = 8'hE4;
        phy_adj_pre = 8'h1B;
        repeat (2) @(negedge clk);
        aux_read(20'h00206, 8'd1, 32'h0000009C, "rd_adj2");

        aux_write(20'h00101, 8'd0, 32'h04, "wr_lane4");
        check_eq("lane4", {30'b0, rx_lane_count}, 32'h2);
        phy_eq_done         = 4'h5;
        phy_symbol_lock     = 4'h3;
        phy_interlane_align = 1'b1;
        repeat (2) @(negedge clk);
        aux_read(20'h00202, 8'd2, 32'h00011357, "rd_stat4");
        aux_read(20'h00207, 8'd0, 32'h00000036, "rd_adj4");
        aux_read(20'h00101, 8'd0, 32'h00000004, "rd_lanecnt");

        aux_read(20'hFFFFF, 8'd1, 32'h00001200, "rd_wrap");

        aux_write(20'h00102, 8'd0, 32'h03, "wr_tps3");
        check_eq("tps3", {30'b0, rx_tps}, 32'h3);

`ifdef LT_IRQ_EN
        aux_write(20'h00101, 8'd0, 32'h01, "irq_lane1");
        aux_write(20'h00102, 8'd0, 32'h00, "irq_tps0");
        @(negedge clk);
        phy_cr_lock = 4'hE;
        irq_cnt     = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            irq_cnt += int'(hpd_irq);
        end
        check_eq("irq tps0", irq_cnt, 32'd1);
        phy_cr_lock = 4'hF;
        aux_write(20'h00102, 8'd0, 32'h01, "irq_tps1");
        @(negedge clk);
        phy_cr_lock = 4'hE;
        irq_cnt     = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            irq_cnt += int'(hpd_irq);
        end
        check_eq("irq tps1", irq_cnt, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
